// File: rtl/sync_debounce.sv
// sync_debounce: per-channel synchronizer and debounce filter with registered level and edge strobes
module sync_debounce #(
  parameter int WIDTH = 4,
  parameter int STAGES = 2,
  parameter int DB_CYCLES = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_a,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  typedef enum logic {STABLE, PENDING} state_t;
  logic [WIDTH-1:0] sync [STAGES];
  logic [WIDTH-1:0] s, diff, acc, q_d, rise_d, fall_d;
  logic [CW-1:0] cnt [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  state_t st [WIDTH];
  state_t st_d [WIDTH];
  assign s = sync[STAGES-1];
  assign diff = s ^ q;
  // plain flop chain per bit; nothing may sit between stages
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) sync[k] <= RST_VAL;
    end else begin
      sync[0] <= d_a;
      for (int k = 1; k < STAGES; k++) sync[k] <= sync[k-1];
    end
  end
  // per-bit debounce: a difference must persist DB_CYCLES cycles, any agreement restarts it
  always_comb begin
    acc = '0;
    cnt_d = '{default: '0};
    st_d = '{default: STABLE};
    for (int b = 0; b < WIDTH; b++) begin
      acc[b] = diff[b] && (cnt[b] == LAST);
      cnt_d[b] = (!diff[b] || acc[b]) ? '0 : (st[b] == PENDING ? cnt[b] + 1'b1 : CW'(1));
      st_d[b] = (diff[b] && !acc[b]) ? PENDING : STABLE;
    end
    q_d = q ^ acc;
    rise_d = acc & s;
    fall_d = acc & ~s;
  end
  // level, strobes and per-bit state all register together so pulses align with q
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RST_VAL;
      rise <= '0;
      fall <= '0;
      changed <= 1'b0;
      for (int b = 0; b < WIDTH; b++) begin
        cnt[b] <= '0;
        st[b] <= STABLE;
      end
    end else begin
      q <= q_d;
      rise <= rise_d;
      fall <= fall_d;
      changed <= |acc;
      for (int b = 0; b < WIDTH; b++) begin
        cnt[b] <= cnt_d[b];
        st[b] <= st_d[b];
      end
    end
  end
endmodule
